// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive sequencer: scan-code prefix constants,
// sequencer state encoding and the 10-bit event layout {ext, brk, code}.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;  // extended-key prefix
    localparam logic [7:0] PS2_BRK  = 8'hF0;  // break (key release) prefix
    localparam logic [7:0] PS2_OVR0 = 8'h00;  // device overrun / error code
    localparam logic [7:0] PS2_OVR1 = 8'hFF;  // device overrun / error code

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam int EVENT_W = $bits(ps2_event_t);

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

    function automatic logic is_overrun(input logic [7:0] b);
        return (b == PS2_OVR0) || (b == PS2_OVR1);
    endfunction

    function automatic ps2_event_t mk_event(input logic ext, input logic brk,
                                            input logic [7:0] code);
        ps2_event_t ev;
        ev.ext  = ext;
        ev.brk  = brk;
        ev.code = code;
        return ev;
    endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// Small synchronous FIFO holding decoded scan-code events. A push into a full
// FIFO succeeds only when a pop happens in the same cycle; otherwise it is
// ignored and the caller decides how to report the drop.
module ps2_code_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage write; entries become meaningful only once count covers them.
    // NOTE: the array has no reset -- pointers and count define what is valid,
    // and leaving it unreset lets it map onto plain RAM/flops without reset muxes.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of 2 so pointers wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_sequencer.sv
// PS/2 receive sequencer: gates the frame receiver, folds E0/F0 prefixes into
// scan-code events, buffers them in an event FIFO and presents them to the
// consumer with a valid/ready handshake.
// Optional feature: define PS2_SEQ_TIMEOUT_EN to add a watchdog that abandons
// a prefix sequence whose final byte does not arrive within TIMEOUT_CYCLES.
module ps2_rx_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
`ifdef PS2_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 50000
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic       rx_en,
    input  logic       hold_data,
    output logic [7:0] code_data,
    output logic       code_ext,
    output logic       code_break,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       rx_complete,
    input  logic       ovf_clr,
    output logic       overflow,
    output logic [7:0] err_cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    seq_state_t       state;
    seq_state_t       state_next;
    logic             push_req;
    ps2_event_t       push_evt;
    logic             err_evt;
    logic             timeout;
    logic             running;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [EVENT_W-1:0] fifo_dout;
    ps2_event_t       head;
    logic             drop;

    ps2_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .pop     (fifo_pop),
        .din     (push_evt),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Head is blanked while empty so the outputs read 0 instead of stale storage.
    assign head        = fifo_empty ? '0 : ps2_event_t'(fifo_dout);
    assign code_data   = head.code;
    assign code_ext    = head.ext;
    assign code_break  = head.brk;
    assign code_valid  = ~fifo_empty & ~hold_data;
    assign fifo_pop    = code_valid & code_ready;
    assign drop        = push_req & fifo_full & ~fifo_pop;
    // Keep one free slot so a frame already on the wire when we inhibit still fits.
    assign rx_en       = running & (fifo_count < CNT_W'(FIFO_DEPTH - 1));

`ifdef PS2_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // Watchdog: counts idle cycles while a prefix is pending, restarts on every byte.
    always_ff @(posedge clk) begin
        if (!reset_n || state == ST_IDLE || rx_valid) begin
            wd_cnt <= '0;
        end else if (!timeout) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign timeout = (state != ST_IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Prefix decoding: next state, event push and error reporting.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        push_evt   = '0;
        err_evt    = 1'b0;
        if (rx_err) begin
            err_evt    = 1'b1;
            state_next = ST_IDLE;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_byte == PS2_EXT) begin
                        state_next = ST_GOT_E0;
                    end else if (rx_byte == PS2_BRK) begin
                        state_next = ST_GOT_F0;
                    end else if (is_overrun(rx_byte)) begin
                        err_evt = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        push_evt = mk_event(1'b0, 1'b0, rx_byte);
                    end
                end
                ST_GOT_E0: begin
                    if (rx_byte == PS2_BRK) begin
                        state_next = ST_GOT_E0F0;
                    end else if (rx_byte != PS2_EXT) begin
                        push_req   = 1'b1;
                        push_evt   = mk_event(1'b1, 1'b0, rx_byte);
                        state_next = ST_IDLE;
                    end
                end
                ST_GOT_F0: begin
                    state_next = ST_IDLE;
                    if (is_prefix(rx_byte)) begin
                        err_evt = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        push_evt = mk_event(1'b0, 1'b1, rx_byte);
                    end
                end
                ST_GOT_E0F0: begin
                    state_next = ST_IDLE;
                    if (is_prefix(rx_byte)) begin
                        err_evt = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        push_evt = mk_event(1'b1, 1'b1, rx_byte);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (timeout) begin
            err_evt    = 1'b1;
            state_next = ST_IDLE;
        end
    end

    // Status flags: receiver-enable gate, push strobe, sticky overflow, error counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            running     <= 1'b0;
            rx_complete <= 1'b0;
            overflow    <= 1'b0;
            err_cnt     <= '0;
        end else begin
            running     <= 1'b1;
            rx_complete <= push_req & ~drop;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule
